// File: rtl/lct_quality_run3_pipe.sv
// lct_quality_run3_pipe
//
// Registered multi-LCT Run-3 GEM-CSC quality encoder with per-code
// occupancy monitoring. Sits between the ALCT-CLCT-GEM matching stage and
// the LCT sorter / MPC formatter.
//
// Stage 1 assigns a 3-bit quality code to each of NLCT candidates, with one
// clock of latency. Stage 2 counts the registered codes in eight saturating
// counters, one per code. Stage 3 registers the counter chosen by cnt_sel.
//
// Ports
//   clock, reset_n           40 MHz clock, asynchronous active-low reset
//   lct_vld[NLCT]            candidate i present this BX
//   *_match[NLCT]            ALCT/CLCT/GEM match flags per candidate
//   gemcsc_bend_enable[NLCT] GEM-CSC bend angle usable for candidate i
//   q_vld[NLCT], q[3*NLCT]   registered quality; LCT i is in q[3i+2:3i]
//   cnt_clear                synchronous clear of all counters and ovf flags
//   cnt_freeze               hold counters and ovf flags
//   cnt_sel[3]               quality code whose counter is read
//   cnt_rd[CNTW]             registered count for code cnt_sel
//   cnt_ovf[8]               sticky saturation flag per code
module lct_quality_run3_pipe #(
    parameter int NLCT = 2,   // 1..4
    parameter int CNTW = 16   // 4..32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NLCT-1:0]   lct_vld,
    input  logic [NLCT-1:0]   alct_clct_copad_match,
    input  logic [NLCT-1:0]   alct_clct_gem_match,
    input  logic [NLCT-1:0]   alct_clct_match,
    input  logic [NLCT-1:0]   clct_copad_match,
    input  logic [NLCT-1:0]   alct_copad_match,
    input  logic [NLCT-1:0]   gemcsc_bend_enable,
    output logic [NLCT-1:0]   q_vld,
    output logic [3*NLCT-1:0] q,
    input  logic              cnt_clear,
    input  logic              cnt_freeze,
    input  logic [2:0]        cnt_sel,
    output logic [CNTW-1:0]   cnt_rd,
    output logic [7:0]        cnt_ovf
);

    // Largest count a CNTW-bit counter can hold, in the widened sum width.
    localparam logic [CNTW:0] CNT_MAX = {1'b0, {CNTW{1'b1}}};

    // ------------------------------------------------------------------
    // Stage 1: per-LCT priority encode
    // ------------------------------------------------------------------
    logic [3*NLCT-1:0] q_next;

    // NOTE: every variable driven in always_comb gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        q_next = '0;
        for (int i = 0; i < NLCT; i++) begin
            if (!lct_vld[i]) begin
                q_next[3*i +: 3] = 3'd0;
            end else if (alct_clct_copad_match[i]) begin
                q_next[3*i +: 3] = gemcsc_bend_enable[i] ? 3'd7 : 3'd6;
            end else if (alct_clct_gem_match[i]) begin
                q_next[3*i +: 3] = gemcsc_bend_enable[i] ? 3'd5 : 3'd4;
            end else if (alct_clct_match[i]) begin
                q_next[3*i +: 3] = 3'd3;
            end else if (clct_copad_match[i]) begin
                // CLCT+copad outranks ALCT+copad even though its code is lower.
                q_next[3*i +: 3] = 3'd1;
            end else if (alct_copad_match[i]) begin
                q_next[3*i +: 3] = 3'd2;
            end else begin
                q_next[3*i +: 3] = 3'd0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q     <= '0;
            q_vld <= '0;
        end else begin
            q     <= q_next;
            q_vld <= lct_vld;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: per-code hit count from the registered qualities
    // ------------------------------------------------------------------
    logic [2:0]      hits [8];   // 0..NLCT, NLCT <= 4
    logic [CNTW:0]   sums [8];
    logic [CNTW-1:0] cnt  [8];

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            hits[c] = 3'd0;
            for (int i = 0; i < NLCT; i++) begin
                if (q_vld[i] && (q[3*i +: 3] == 3'(c))) begin
                    hits[c] = hits[c] + 3'd1;
                end
            end
            sums[c] = {1'b0, cnt[c]} + {{(CNTW-2){1'b0}}, hits[c]};
        end
    end

    // NOTE: the counter array is a handful of flops that must read zero after
    // reset, so it is reset explicitly rather than treated as a RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 8; c++) begin
                cnt[c] <= '0;
            end
            cnt_ovf <= '0;
        end else if (cnt_clear) begin
            // Whatever sits in the counting stage this cycle is dropped.
            for (int c = 0; c < 8; c++) begin
                cnt[c] <= '0;
            end
            cnt_ovf <= '0;
        end else if (!cnt_freeze) begin
            for (int c = 0; c < 8; c++) begin
                if (sums[c] > CNT_MAX) begin
                    cnt[c]     <= '1;
                    cnt_ovf[c] <= 1'b1;
                end else begin
                    cnt[c] <= sums[c][CNTW-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: readout of the selected counter (pre-update value)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_rd <= '0;
        end else begin
            cnt_rd <= cnt[cnt_sel];
        end
    end

endmodule

// File: doc/lct_quality_run3_pipe.md
# lct_quality_run3_pipe

Registered, multi-LCT successor to the Run-3 GEM-CSC LCT quality encoder. Each bunch crossing it assigns a 3-bit quality code to up to NLCT LCT candidates from their ALCT/CLCT/GEM match flags and per-LCT GEM-CSC bend enable. It keeps saturating per-code occupancy counters for monitoring readout. It sits between the ALCT-CLCT-GEM matching stage and the LCT sorter/MPC formatter.

## Interface
Parameters:
- NLCT, 2, LCT candidates per BX (1..4)
- CNTW, 16, occupancy counter width (4..32)

Ports:
- clock  in  1  system 40 MHz clock
- reset_n  in  1  asynchronous active-low reset
- lct_vld  in  NLCT  candidate i present this BX
- alct_clct_copad_match  in  NLCT  ALCT+CLCT+GEM copad matched
- alct_clct_gem_match  in  NLCT  ALCT+CLCT+single GEM pad matched
- alct_clct_match  in  NLCT  ALCT+CLCT matched, no GEM
- clct_copad_match  in  NLCT  CLCT+copad, no ALCT
- alct_copad_match  in  NLCT  ALCT+copad, no CLCT
- gemcsc_bend_enable  in  NLCT  GEM-CSC bend angle usable
- q_vld  out  NLCT  registered quality valid
- q  out  3*NLCT  registered quality, LCT i in bits [3i+2:3i]
- cnt_clear  in  1  synchronous clear of all counters and overflow flags
- cnt_freeze  in  1  hold counters
- cnt_sel  in  3  quality code to read
- cnt_rd  out  CNTW  registered count for code cnt_sel
- cnt_ovf  out  8  sticky saturation flag per code

## Operation
- Per-LCT priority encode, evaluated in this order:
  - copad match with bend enabled → 7; copad match with bend disabled → 6
  - gem match with bend enabled → 5; gem match with bend disabled → 4
  - alct_clct_match → 3
  - clct_copad_match → 1
  - alct_copad_match → 2
  - none → 0
- Match flags of LCT i are ignored when lct_vld[i]=0. In that case q_i=0, q_vld[i]=0, and the LCT is not counted.
- A valid LCT with no match flags gets Q=0, q_vld=1, and is counted in code 0.
- Counting stage uses registered q/q_vld. For each code c, cnt[c] += number of LCTs with q_vld=1 and q=c that cycle (0..NLCT).
- Counter arithmetic is done in CNTW+1 bits. A result above 2^CNTW−1 clamps to all-ones and sets cnt_ovf[c]. A counter already at all-ones stays there, and adding 0 to it does not set ovf.
- Priority: cnt_clear > cnt_freeze > increment.
  - cnt_clear zeroes all counters and cnt_ovf in the next cycle; LCTs arriving at the counting stage that cycle are dropped.
  - cnt_freeze blocks increments and ovf updates. Quality outputs are unaffected.
- cnt_rd registers cnt[cnt_sel] every cycle.

## Timing
- Reset (reset_n=0, asynchronous): q=0, q_vld=0, all counters 0, cnt_ovf=0, cnt_rd=0. Release is synchronous to clock.
- Quality latency is 1 clock: inputs sampled at edge N appear on q/q_vld after edge N.
- Counter update lands at edge N+1 for inputs sampled at edge N. cnt_rd reflects it after edge N+2 with a stable cnt_sel.
- Read latency is 1 clock from a cnt_sel change, returning the counter value present before that edge.
- Back-to-back BX: full throughput with no bubbles, one result per LCT per clock.
- Reset mid-stream discards all in-flight results and counts.

## Test plan
- Priority: NLCT=2, lct_vld=2'b11. LCT0 has all five flags=1 and bend=1; LCT1 has alct_copad=1 and clct_copad=1. Required response one cycle later: q=6'b001_111, q_vld=2'b11.
- Masking and bend: lct_vld=2'b01, LCT0 gem=1 with bend=0, LCT1 copad=1 with bend=1. Required response: q[2:0]=4, q[5:3]=0, q_vld=2'b01; after three more clocks, cnt_sel=4 → cnt_rd=1 and cnt_sel=7 → cnt_rd=0.
- Multi-increment: both LCTs alct_clct_match=1 for 5 consecutive BX. Required response: cnt_sel=3 → cnt_rd=10 and cnt_ovf=0.
- Saturation with CNTW=4: drive both LCTs to Q=3 for 8 BX. Required response: count 14 after 7 BX, then 15 with cnt_ovf[3]=1 after the 8th; further hits keep 15.
- Clear/freeze: with freeze=1, drive 3 BX of Q=1 → count unchanged. Then assert clear=1 and freeze=1 in the same cycle as a Q=1 arrival → count 0 and cnt_ovf=0, with the arrival dropped.
- Async reset: assert reset_n=0 mid-stream between clock edges. Required response: q, q_vld, counters, and cnt_rd are 0 immediately; the first valid input after release yields q one clock later.
